// File: rtl/pipeline_types_pkg.sv
// Shared pipeline types: stage payload structs and the skid-register occupancy enum.
package pipeline_types;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } storage_t;

  function automatic logic [1:0] skid_count(input skid_state_t s);
    case (s)
      SKID_ONE: return 2'd1;
      SKID_TWO: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_data_slot.sv
// One WIDTH-bit payload register: load-enabled, async reset and sync clear to RESET_DATA.
module pipe_data_slot #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (clear)
      data_d = RESET_DATA;
    else if (load)
      data_d = d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_q <= RESET_DATA;
    else
      data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid_register.sv
// Valid/ready pipeline stage register; SKID=1 adds a second entry so in_ready is a pure state decode.
module pipe_skid_register
  import pipeline_types::*;
#(
  parameter int unsigned      WIDTH      = 32,
  parameter bit               SKID       = 1'b1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_t      state_q, state_d;
  logic             accept, take;
  logic             main_load, skid_load, clear;
  logic             ready_raw;
  logic [WIDTH-1:0] main_d, skid_data;

  // Skid mode never looks at out_ready here; single-entry mode passes it through.
  always_comb begin
    if (SKID)
      ready_raw = (state_q != SKID_TWO);
    else
      ready_raw = (state_q == SKID_EMPTY) | out_ready;
    in_ready = ready_raw & ~flush & ~rst;
  end

  assign out_valid = (state_q != SKID_EMPTY);
  assign count     = skid_count(state_q);
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    skid_load = 1'b0;
    clear     = 1'b0;
    if (flush) begin
      state_d = SKID_EMPTY;
      clear   = 1'b1;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            state_d   = SKID_ONE;
            main_load = 1'b1;
          end
        end
        SKID_ONE: begin
          if (accept && take) begin
            main_load = 1'b1;
          end else if (accept) begin
            if (SKID) begin
              state_d   = SKID_TWO;
              skid_load = 1'b1;
            end
          end else if (take) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (take) begin
            state_d   = SKID_ONE;
            main_load = 1'b1;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= SKID_EMPTY;
    else
      state_q <= state_d;
  end

  // Draining from TWO promotes the skid entry; every other main load comes from the input.
  assign main_d = (state_q == SKID_TWO) ? skid_data : in_data;

  pipe_data_slot #(
    .WIDTH      (WIDTH),
    .RESET_DATA (RESET_DATA)
  ) u_main (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .load  (main_load),
    .d     (main_d),
    .q     (out_data)
  );

  if (SKID) begin : g_skid
    pipe_data_slot #(
      .WIDTH      (WIDTH),
      .RESET_DATA (RESET_DATA)
    ) u_skid (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .load  (skid_load),
      .d     (in_data),
      .q     (skid_data)
    );
  end else begin : g_no_skid
    assign skid_data = RESET_DATA;
  end

endmodule

// File: tb/tb_pipe_skid_register.sv
// Bench for pipe_skid_register: directed vector table, reset corner case, and random traffic vs a queue model.
module tb_pipe_skid_register;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [W-1:0] in_data   [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [W-1:0] out_data  [2];
  logic [1:0]   count     [2];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_skid_register #(.WIDTH(W), .SKID(1'b0), .RESET_DATA('0)) u_s0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .count(count[0])
  );

  pipe_skid_register #(.WIDTH(W), .SKID(1'b1), .RESET_DATA('0)) u_s1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .count(count[1])
  );

  typedef struct packed {
    logic         m;
    logic         fl;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [W-1:0] e_data;
    logic [1:0]   e_cnt;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] sb[$];

  function automatic vec_t mk(logic m, logic fl, logic iv, logic [W-1:0] d, logic ordy,
                              logic e_ir, logic e_ov, logic [W-1:0] e_data, logic [1:0] e_cnt);
    vec_t v;
    v.m = m; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_data = e_data; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_all();
    flush = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b0;
    end
  endtask

  task automatic run_random(input int m, input int n);
    logic         iv, ordy, fl, ir, ir_a, ir_b, ov, exp_ir;
    logic [W-1:0] d, od, prev_data;
    logic         prev_stall;
    @(negedge clk);
    idle_all();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      fl   = ($urandom_range(0, 63) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      d    = W'($urandom);
      flush        = fl;
      in_valid[m]  = iv;
      in_data[m]   = d;
      out_ready[m] = 1'b0;
      #1 ir_a = in_ready[m];
      out_ready[m] = 1'b1;
      #1 ir_b = in_ready[m];
      out_ready[m] = ordy;
      #1;
      ir = in_ready[m];
      ov = out_valid[m];
      od = out_data[m];
      if (m == 1) check("s1 ready independent of out_ready", 32'(ir_a), 32'(ir_b));
      exp_ir = !fl && ((m == 1) ? (sb.size() < 2) : (sb.size() == 0 || ordy));
      check($sformatf("rnd%0d in_ready", m), 32'(ir), 32'(exp_ir));
      check($sformatf("rnd%0d out_valid", m), 32'(ov), 32'(sb.size() != 0));
      check($sformatf("rnd%0d count", m), 32'(count[m]), 32'(sb.size()));
      if (prev_stall) check($sformatf("rnd%0d stall data", m), 32'(od), 32'(prev_data));
      if (ov && ordy) begin
        if (sb.size() == 0) check($sformatf("rnd%0d take on empty model", m), 32'(1), 32'(0));
        else check($sformatf("rnd%0d order", m), 32'(od), 32'(sb.pop_front()));
      end
      if (iv && ir) sb.push_back(d);
      if (fl) sb.delete();
      prev_stall = ov && !ordy && !fl;
      prev_data  = od;
      @(posedge clk);
    end
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    idle_all();
    rst = 1'b1;

    // T1: SKID=1 streaming
    vecs.push_back(mk(1,0,1,8'h0A,1, 1,1,8'h0A,1));
    vecs.push_back(mk(1,0,1,8'h0B,1, 1,1,8'h0B,1));
    vecs.push_back(mk(1,0,1,8'h0C,1, 1,1,8'h0C,1));
    vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h0C,0));
    // T2: SKID=1 fill to TWO, then drain in order
    vecs.push_back(mk(1,0,1,8'h11,0, 1,1,8'h11,1));
    vecs.push_back(mk(1,0,1,8'h22,0, 1,1,8'h11,2));
    vecs.push_back(mk(1,0,1,8'h33,0, 0,1,8'h11,2));
    vecs.push_back(mk(1,0,1,8'h33,1, 0,1,8'h22,1));
    vecs.push_back(mk(1,0,1,8'h33,1, 1,1,8'h33,1));
    vecs.push_back(mk(1,0,0,8'h00,1, 1,0,8'h33,0));
    // T3: SKID=1 flush from TWO with a competing input
    vecs.push_back(mk(1,0,1,8'h11,0, 1,1,8'h11,1));
    vecs.push_back(mk(1,0,1,8'h22,0, 1,1,8'h11,2));
    vecs.push_back(mk(1,1,1,8'h44,0, 0,0,8'h00,0));
    vecs.push_back(mk(1,0,0,8'h00,0, 1,0,8'h00,0));
    // T4: SKID=0 ready pass-through and same-cycle replace, then flush with take
    vecs.push_back(mk(0,0,1,8'h55,0, 1,1,8'h55,1));
    vecs.push_back(mk(0,0,1,8'h99,0, 0,1,8'h55,1));
    vecs.push_back(mk(0,0,1,8'h66,1, 1,1,8'h66,1));
    vecs.push_back(mk(0,0,0,8'h00,1, 1,0,8'h66,0));
    vecs.push_back(mk(0,0,1,8'h77,0, 1,1,8'h77,1));
    vecs.push_back(mk(0,1,1,8'h88,1, 0,0,8'h00,0));

    #12;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset%0d out_valid", k), 32'(out_valid[k]), 32'(0));
      check($sformatf("reset%0d count", k), 32'(count[k]), 32'(0));
      check($sformatf("reset%0d in_ready", k), 32'(in_ready[k]), 32'(0));
      check($sformatf("reset%0d out_data", k), 32'(out_data[k]), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("post-reset%0d in_ready", k), 32'(in_ready[k]), 32'(1));

    foreach (vecs[i]) begin
      @(negedge clk);
      idle_all();
      flush                = vecs[i].fl;
      in_valid[vecs[i].m]  = vecs[i].iv;
      in_data[vecs[i].m]   = vecs[i].d;
      out_ready[vecs[i].m] = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d in_ready", i), 32'(in_ready[vecs[i].m]), 32'(vecs[i].e_ir));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d out_valid", i), 32'(out_valid[vecs[i].m]), 32'(vecs[i].e_ov));
      check($sformatf("vec%0d out_data", i), 32'(out_data[vecs[i].m]), 32'(vecs[i].e_data));
      check($sformatf("vec%0d count", i), 32'(count[vecs[i].m]), 32'(vecs[i].e_cnt));
    end

    // T5: asynchronous reset between edges while holding two entries
    @(negedge clk);
    idle_all();
    in_valid[1] = 1'b1; in_data[1] = 8'h11;
    @(negedge clk);
    in_data[1] = 8'h22;
    @(negedge clk);
    in_valid[1] = 1'b0;
    #1 check("pre-rst count", 32'(count[1]), 32'(2));
    #1 rst = 1'b1;
    #1;
    check("mid-rst out_valid", 32'(out_valid[1]), 32'(0));
    check("mid-rst count", 32'(count[1]), 32'(0));
    check("mid-rst in_ready", 32'(in_ready[1]), 32'(0));
    check("mid-rst out_data", 32'(out_data[1]), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    in_valid[1] = 1'b1; in_data[1] = 8'h77; out_ready[1] = 1'b1;
    #1 check("after-rst in_ready", 32'(in_ready[1]), 32'(1));
    @(posedge clk);
    #1;
    check("after-rst out_valid", 32'(out_valid[1]), 32'(1));
    check("after-rst out_data", 32'(out_data[1]), 32'(8'h77));

    run_random(1, 5000);
    run_random(0, 5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
